// File: rtl/hex_parse_pkg.sv
// Shared types and ASCII constants for the hex-token parser.
package hex_parse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CC_INVALID = 2'd0,
    CC_DIGIT   = 2'd1,
    CC_DELIM   = 2'd2
  } char_class_t;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_A   = 8'h41;
  localparam logic [7:0] CH_F   = 8'h46;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LF_ = 8'h66;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_NL  = 8'h0A;

  function automatic logic in_range(logic [7:0] ch, logic [7:0] lo, logic [7:0] hi);
    return (ch >= lo) && (ch <= hi);
  endfunction

endpackage

// File: rtl/hex_char_decode.sv
// Combinational ASCII character classifier and hex nibble decoder.
// Define HEX_LOWERCASE_EN to also accept 'a'-'f' as hex digits.
module hex_char_decode
  import hex_parse_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_digit,
  output logic       is_delim,
  output logic [3:0] nib
);

  char_class_t cls_s;

  // Classify the character; letters map to 10..15 by adding 9 to their low nibble.
  always_comb begin
    cls_s = CC_INVALID;
    nib   = 4'h0;
    if (in_range(in_char, CH_0, CH_9)) begin
      cls_s = CC_DIGIT;
      nib   = in_char[3:0];
    end else if (in_range(in_char, CH_A, CH_F)) begin
      cls_s = CC_DIGIT;
      nib   = in_char[3:0] + 4'd9;
`ifdef HEX_LOWERCASE_EN
    end else if (in_range(in_char, CH_LA, CH_LF_)) begin
      cls_s = CC_DIGIT;
      nib   = in_char[3:0] + 4'd9;
`endif
    end else if ((in_char == CH_SP) || (in_char == CH_CR) || (in_char == CH_NL)) begin
      cls_s = CC_DELIM;
    end else begin
      cls_s = CC_INVALID;
    end
  end

  // Expand the class into the two flags the FSM consumes.
  always_comb begin
    case (cls_s)
      CC_DIGIT: begin
        is_digit = 1'b1;
        is_delim = 1'b0;
      end
      CC_DELIM: begin
        is_digit = 1'b0;
        is_delim = 1'b1;
      end
      default: begin
        is_digit = 1'b0;
        is_delim = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hex_ascii_to_word.sv
// Assembles delimited ASCII hex tokens into right-aligned binary words.
// Optional macro HEX_LOWERCASE_EN (see hex_char_decode) enables lowercase digits.
module hex_ascii_to_word
  import hex_parse_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_char,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_W-1:0]                out_data,
  output logic [$clog2(WORD_W/4+1)-1:0]    out_ndigits,
  output logic                             out_err
);

  localparam int MAXDIG = WORD_W / 4;
  localparam int CNT_W  = $clog2(MAXDIG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXDIG);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_r;
  logic [WORD_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_digit_s;
  logic              is_delim_s;
  logic [3:0]        nib_s;
  logic              accept_s;

  hex_char_decode u_decode (
    .in_char  (in_char),
    .is_digit (is_digit_s),
    .is_delim (is_delim_s),
    .nib      (nib_s)
  );

  // Held low during reset so nothing is taken while the FSM is being cleared.
  assign in_ready = rst_n & (state_r != DONE);
  assign accept_s = in_valid & in_ready;

  // Token FSM with accumulator, digit counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {WORD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_valid   <= 1'b0;
      out_data    <= {WORD_W{1'b0}};
      out_ndigits <= {CNT_W{1'b0}};
      out_err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && is_digit_s) begin
            acc_r   <= {acc_r[WORD_W-5:0], nib_s};
            cnt_r   <= CNT_ONE;
            state_r <= ACCUM;
          end else if (accept_s && !is_delim_s) begin
            state_r <= SKIP;
          end
        end
        ACCUM: begin
          if (accept_s && is_digit_s) begin
            if (cnt_r == CNT_MAX) begin
              state_r <= SKIP;
            end else begin
              acc_r <= {acc_r[WORD_W-5:0], nib_s};
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else if (accept_s && is_delim_s) begin
            out_valid   <= 1'b1;
            out_data    <= acc_r;
            out_ndigits <= cnt_r;
            out_err     <= 1'b0;
            state_r     <= DONE;
          end else if (accept_s) begin
            state_r <= SKIP;
          end
        end
        SKIP: begin
          if (accept_s && is_delim_s) begin
            out_valid   <= 1'b1;
            out_data    <= {WORD_W{1'b0}};
            out_ndigits <= {CNT_W{1'b0}};
            out_err     <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_r     <= {WORD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_ascii_to_word.sv
// Directed bench: token-level model, per-cycle compare process and literal checks.
module tb_hex_ascii_to_word;

  localparam int MAXDIG = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_ndigits;
  logic        out_err;

  hex_ascii_to_word #(.WORD_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ndigits (out_ndigits),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  n;
    logic        e;
    time         t;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tokq[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          n_results = 0;
  bit          seen_cur  = 1'b0;
  logic [31:0] last_data;
  logic [3:0]  last_nd;
  logic        last_err;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit hexval(logic [7:0] c, output int v);
    v = 0;
    if (c >= 8'h30 && c <= 8'h39) begin v = int'(c) - 48; return 1'b1; end
    if (c >= 8'h41 && c <= 8'h46) begin v = int'(c) - 55; return 1'b1; end
`ifdef HEX_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) begin v = int'(c) - 87; return 1'b1; end
`endif
    return 1'b0;
  endfunction

  // Token-level reference: collect characters, evaluate the whole token at a delimiter.
  task automatic model_char(logic [7:0] c);
    exp_t        e;
    bit          ok;
    int          v;
    longint      val;
    if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
      if (tokq.size() > 0) begin
        ok  = (tokq.size() <= MAXDIG);
        val = 0;
        foreach (tokq[i]) begin
          if (!hexval(tokq[i], v)) ok = 1'b0;
          val = val * 16 + v;
        end
        e.d = ok ? 32'(val) : 32'h0;
        e.n = ok ? 4'(tokq.size()) : 4'h0;
        e.e = !ok;
        e.t = $time;
        exp_q.push_back(e);
        tokq.delete();
      end
    end else begin
      tokq.push_back(c);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ndigits", out_ndigits, 0);
      chk("rst_out_err", out_err, 0);
      seen_cur = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid);
      if (out_valid) begin
        if (!seen_cur) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
          end else begin
            chk("latency", $time - exp_q[0].t, 5);
            n_results++;
            last_data = out_data;
            last_nd   = out_ndigits;
            last_err  = out_err;
            seen_cur  = 1'b1;
          end
        end
        if (exp_q.size() != 0) begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_ndigits", out_ndigits, exp_q[0].n);
          chk("out_err", out_err, exp_q[0].e);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          seen_cur = 1'b0;
        end
      end
    end
  end

  task automatic send_char(logic [7:0] c);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_char(c);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_result(int base, string name);
    int w;
    w = 0;
    while (n_results == base && w < 50) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    chk(name, n_results - base, 1);
  endtask

  task automatic chk_last(string name, logic [31:0] d, logic [3:0] n, logic e);
    chk({name, "_data"}, last_data, d);
    chk({name, "_nd"}, last_nd, n);
    chk({name, "_err"}, last_err, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    base = n_results; send_str("1A2B ");
    wait_result(base, "cnt_1a2b");
    chk_last("t1a2b", 32'h00001A2B, 4'd4, 1'b0);

    base = n_results;
    send_str("  "); send_char(8'h0D); send_str("\nDEADBEEF\n");
    wait_result(base, "cnt_deadbeef");
    chk_last("tdeadbeef", 32'hDEADBEEF, 4'd8, 1'b0);

    base = n_results; send_str("123456789 ");
    wait_result(base, "cnt_ovf");
    chk_last("tovf", 32'h0, 4'd0, 1'b1);
    base = n_results; send_str("7 ");
    wait_result(base, "cnt_recover");
    chk_last("trecover", 32'h7, 4'd1, 1'b0);

    base = n_results; send_str("12G4"); send_char(8'h0D);
    wait_result(base, "cnt_12g4");
    chk_last("t12g4", 32'h0, 4'd0, 1'b1);

    base = n_results; send_str("ff ");
    wait_result(base, "cnt_ff");
`ifdef HEX_LOWERCASE_EN
    chk_last("tff", 32'h000000FF, 4'd2, 1'b0);
`else
    chk_last("tff", 32'h0, 4'd0, 1'b1);
`endif

    base = n_results; send_str("FFFFFFFF ");
    wait_result(base, "cnt_full");
    chk_last("tfull", 32'hFFFFFFFF, 4'd8, 1'b0);

    base = n_results; send_str("G12 ");
    wait_result(base, "cnt_g12");
    chk_last("tg12", 32'h0, 4'd0, 1'b1);

    base = n_results; send_str("0 ");
    wait_result(base, "cnt_zero");
    chk_last("tzero", 32'h0, 4'd1, 1'b0);

    out_ready = 1'b0;
    base = n_results; send_str("5 ");
    repeat (5) @(posedge clk);
    #1;
    chk("hold_out_valid", out_valid, 1);
    chk("hold_out_data", out_data, 32'h5);
    chk("hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    wait_result(base, "cnt_hold");
    chk_last("thold", 32'h5, 4'd1, 1'b0);

    send_str("ABC");
    @(posedge clk);
    #1 rst_n = 1'b0;
    tokq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = n_results; send_str("9 ");
    wait_result(base, "cnt_after_reset");
    chk_last("treset", 32'h9, 4'd1, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
